// File: rtl/wb_arb_pkg.sv
// Writeback arbiter shared package.
// Core-default widths, the slot entry type and the round-robin step.
package wb_arb_pkg;

   localparam int INST_ID_BITS = 6;
   localparam int PRN_BITS     = 6;
   localparam int MAX_OPERANDS = 3;
   localparam int FU_COUNT     = 4;
   localparam int DATA_BITS    = 64;

   typedef struct packed {
      logic                                   valid;
      logic [INST_ID_BITS-1:0]                inst_id;
      logic [MAX_OPERANDS-1:0]                prn_valid;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn;
      logic [MAX_OPERANDS-1:0][DATA_BITS-1:0] data;
   } wb_entry_t;

   function automatic int unsigned rr_next(
      input int unsigned ptr,
      input int unsigned fu_count
   );
      return (ptr + 32'd1 >= fu_count) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/wb_arb_if.sv
// Writeback arbiter bus: FU result handshake in, PRF/ROB/wakeup out.
// slave = arbiter view, master = FU/consumer view.
interface wb_arb_if #(
   parameter int INST_ID_BITS = wb_arb_pkg::INST_ID_BITS,
   parameter int PRN_BITS     = wb_arb_pkg::PRN_BITS,
   parameter int MAX_OPERANDS = wb_arb_pkg::MAX_OPERANDS,
   parameter int FU_COUNT     = wb_arb_pkg::FU_COUNT,
   parameter int DATA_BITS    = wb_arb_pkg::DATA_BITS
);
   import wb_arb_pkg::*;

   localparam int SRC_BITS = $clog2(FU_COUNT);

   logic [FU_COUNT-1:0]     fu_valid;
   logic [FU_COUNT-1:0]     fu_ready;
   logic [INST_ID_BITS-1:0] fu_inst_id   [FU_COUNT];
   logic [MAX_OPERANDS-1:0] fu_prn_valid [FU_COUNT];
   logic [PRN_BITS-1:0]     fu_prn       [FU_COUNT][MAX_OPERANDS];
   logic [DATA_BITS-1:0]    fu_data      [FU_COUNT][MAX_OPERANDS];

   logic [MAX_OPERANDS-1:0] prf_write_enable;
   logic [PRN_BITS-1:0]     prf_write_prn [MAX_OPERANDS];
   logic [DATA_BITS-1:0]    prf_write     [MAX_OPERANDS];
   logic [MAX_OPERANDS-1:0] set_prn_ready;
   logic [PRN_BITS-1:0]     set_prn       [MAX_OPERANDS];
   logic                    wb_valid;
   logic [INST_ID_BITS-1:0] wb_inst_id;
   logic [SRC_BITS-1:0]     wb_src;

   modport slave (
      input  fu_valid, fu_inst_id, fu_prn_valid, fu_prn, fu_data,
      output fu_ready,
      output prf_write_enable, prf_write_prn, prf_write,
      output set_prn_ready, set_prn,
      output wb_valid, wb_inst_id, wb_src
   );

   modport master (
      output fu_valid, fu_inst_id, fu_prn_valid, fu_prn, fu_data,
      input  fu_ready,
      input  prf_write_enable, prf_write_prn, prf_write,
      input  set_prn_ready, set_prn,
      input  wb_valid, wb_inst_id, wb_src
   );

endinterface

// File: rtl/wb_arbiter_rr.sv
// Combinational round-robin picker: first request at or after
// i_ptr, wrapping modulo N. One-hot grant plus its index.
module rr_arbiter #(
   parameter int N        = 4,
   parameter int IDX_BITS = 2
) (
   input  logic [N-1:0]        i_req,
   input  logic [IDX_BITS-1:0] i_ptr,
   output logic [N-1:0]        o_grant,
   output logic [IDX_BITS-1:0] o_idx,
   output logic                o_any
);

   logic [IDX_BITS:0] w_pos;

   // Walk the requests from the pointer; the first hit wins
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_pos   = '0;
      for (int off = 0; off < N; off++) begin
         w_pos = {1'b0, i_ptr} + (IDX_BITS+1)'(off);
         if (w_pos >= (IDX_BITS+1)'(N))
            w_pos = w_pos - (IDX_BITS+1)'(N);
         if (!o_any && i_req[w_pos[IDX_BITS-1:0]]) begin
            o_any                         = 1'b1;
            o_grant[w_pos[IDX_BITS-1:0]] = 1'b1;
            o_idx                         = w_pos[IDX_BITS-1:0];
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding slot per FU, round-robin drain
// into registered PRF/ROB/wakeup outputs. Macro: WB_ARB_BYPASS_EN.
module wb_arbiter #(
   parameter int INST_ID_BITS = 6,
   parameter int PRN_BITS     = 6,
   parameter int MAX_OPERANDS = 3,
   parameter int FU_COUNT     = 4,
   parameter int DATA_BITS    = 64
) (
   input logic       clk,
   input logic       rst,
   wb_arb_if.slave   bus
);
   import wb_arb_pkg::*;

   localparam int SRC_BITS = $clog2(FU_COUNT);

   // Same layout as wb_entry_t, sized by this instance
   typedef struct packed {
      logic                                   valid;
      logic [INST_ID_BITS-1:0]                inst_id;
      logic [MAX_OPERANDS-1:0]                prn_valid;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn;
      logic [MAX_OPERANDS-1:0][DATA_BITS-1:0] data;
   } slot_t;

   slot_t               r_slot [FU_COUNT];
   slot_t               r_wb;
   logic [SRC_BITS-1:0] r_wb_src;
   logic [SRC_BITS-1:0] r_ptr;

   slot_t               w_in   [FU_COUNT];
   slot_t               w_cand [FU_COUNT];
   logic [FU_COUNT-1:0] w_req;
   logic [FU_COUNT-1:0] w_grant;
   logic [FU_COUNT-1:0] w_ready;
   logic [FU_COUNT-1:0] w_load;
   logic [SRC_BITS-1:0] w_idx;
   logic                w_any;

   // Pack each FU's presented result into slot form
   always_comb begin
      for (int i = 0; i < FU_COUNT; i++) begin
         w_in[i].valid     = bus.fu_valid[i];
         w_in[i].inst_id   = bus.fu_inst_id[i];
         w_in[i].prn_valid = bus.fu_prn_valid[i];
         for (int k = 0; k < MAX_OPERANDS; k++) begin
            w_in[i].prn[k]  = bus.fu_prn[i][k];
            w_in[i].data[k] = bus.fu_data[i][k];
         end
      end
   end

   // Requesters: held slots, plus idle FUs when bypass is built in
   always_comb begin
      for (int i = 0; i < FU_COUNT; i++) begin
`ifdef WB_ARB_BYPASS_EN
         w_cand[i] = r_slot[i].valid ? r_slot[i] : w_in[i];
         w_req[i]  = r_slot[i].valid | bus.fu_valid[i];
`else
         w_cand[i] = r_slot[i];
         w_req[i]  = r_slot[i].valid;
`endif
      end
   end

   rr_arbiter #(
      .N        (FU_COUNT),
      .IDX_BITS (SRC_BITS)
   ) u_rr (
      .i_req   (w_req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Ready when empty or draining; a bypassed win skips the slot
   always_comb begin
      for (int i = 0; i < FU_COUNT; i++) begin
         w_ready[i] = !r_slot[i].valid || w_grant[i];
         w_load[i]  = bus.fu_valid[i] && w_ready[i]
                      && !(w_grant[i] && !r_slot[i].valid);
      end
   end

   assign bus.fu_ready = w_ready;

   // Slot capture and release; a refill beats the release
   always_ff @(posedge clk) begin
      for (int i = 0; i < FU_COUNT; i++) begin
         if (!rst)
            r_slot[i] <= '0;
         else if (w_load[i])
            r_slot[i] <= w_in[i];
         else if (w_grant[i])
            r_slot[i].valid <= 1'b0;
      end
   end

   // Winner goes to the writeback registers; pointer moves past it
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wb     <= '0;
         r_wb_src <= '0;
         r_ptr    <= '0;
      end else if (w_any) begin
         r_wb     <= w_cand[w_idx];
         r_wb_src <= w_idx;
         r_ptr    <= SRC_BITS'(rr_next(32'(w_idx), FU_COUNT));
      end else begin
         r_wb.valid <= 1'b0;
      end
   end

   // Registered writeback fans out to PRF write and wakeup ports
   always_comb begin
      bus.wb_valid         = r_wb.valid;
      bus.wb_inst_id       = r_wb.inst_id;
      bus.wb_src           = r_wb_src;
      bus.prf_write_enable = {MAX_OPERANDS{r_wb.valid}} & r_wb.prn_valid;
      bus.set_prn_ready    = {MAX_OPERANDS{r_wb.valid}} & r_wb.prn_valid;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
         bus.prf_write_prn[k] = r_wb.prn[k];
         bus.set_prn[k]       = r_wb.prn[k];
         bus.prf_write[k]     = r_wb.data[k];
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter.
// Scoreboard of expected writebacks, matched by inst_id.
module tb_wb_arbiter;
   import wb_arb_pkg::*;

`ifdef WB_ARB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   typedef struct packed {
      logic [1:0] src;
      wb_entry_t  e;
   } exp_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   exp_t sb [$];

   wb_arb_if bus ();

   wb_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(
      input int fu,
      input int id,
      input logic [MAX_OPERANDS-1:0] pv,
      input logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn,
      input logic [MAX_OPERANDS-1:0][DATA_BITS-1:0] data
   );
      exp_t x;
      x.src         = 2'(fu);
      x.e.valid     = 1'b1;
      x.e.inst_id   = 6'(id);
      x.e.prn_valid = pv;
      x.e.prn       = prn;
      x.e.data      = data;
      return x;
   endfunction

   function automatic logic [MAX_OPERANDS-1:0][DATA_BITS-1:0] rnd_data();
      logic [MAX_OPERANDS-1:0][DATA_BITS-1:0] d;
      for (int k = 0; k < MAX_OPERANDS; k++) d[k] = {$urandom, $urandom};
      return d;
   endfunction

   task automatic put(input exp_t x);
      bus.fu_valid[x.src]     = 1'b1;
      bus.fu_inst_id[x.src]   = x.e.inst_id;
      bus.fu_prn_valid[x.src] = x.e.prn_valid;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
         bus.fu_prn[x.src][k]  = x.e.prn[k];
         bus.fu_data[x.src][k] = x.e.data[k];
      end
   endtask

   // Scoreboard consumer: every writeback must match a pushed entry
   always @(negedge clk) begin : monitor
      int hit;
      if (bus.wb_valid === 1'b1) begin
         hit = -1;
         foreach (sb[j])
            if (hit < 0 && sb[j].e.inst_id === bus.wb_inst_id) hit = j;
         vectors++;
         if (hit < 0) begin
            miscompares++;
            $display("FAIL wb_unexpected: got id=%0d src=%0d, required no writeback",
                     bus.wb_inst_id, bus.wb_src);
         end else begin
            if (bus.wb_src !== sb[hit].src ||
                bus.prf_write_enable !== sb[hit].e.prn_valid ||
                bus.set_prn_ready !== sb[hit].e.prn_valid) begin
               miscompares++;
               $display("FAIL wb_meta id=%0d: got src=%0d en=%b rdy=%b, required src=%0d en=%b",
                        bus.wb_inst_id, bus.wb_src, bus.prf_write_enable,
                        bus.set_prn_ready, sb[hit].src, sb[hit].e.prn_valid);
            end
            for (int k = 0; k < MAX_OPERANDS; k++) begin
               if (sb[hit].e.prn_valid[k]) begin
                  vectors++;
                  if (bus.prf_write_prn[k] !== sb[hit].e.prn[k] ||
                      bus.set_prn[k] !== sb[hit].e.prn[k] ||
                      bus.prf_write[k] !== sb[hit].e.data[k]) begin
                     miscompares++;
                     $display("FAIL wb_payload id=%0d k=%0d: got prn=%0d/%0d data=%h, required prn=%0d data=%h",
                              bus.wb_inst_id, k, bus.prf_write_prn[k], bus.set_prn[k],
                              bus.prf_write[k], sb[hit].e.prn[k], sb[hit].e.data[k]);
                  end
               end
            end
            sb.delete(hit);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 4; i++)
         put(mk(i, 40 + i, 3'b111, {6'd3, 6'd2, 6'd1}, rnd_data()));
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if (bus.fu_ready !== 4'hF || bus.wb_valid !== 1'b0 ||
             bus.prf_write_enable !== 3'b000 || bus.set_prn_ready !== 3'b000 ||
             bus.wb_src !== 2'd0 || bus.wb_inst_id !== 6'd0 ||
             bus.prf_write_prn[0] !== 6'd0 || bus.prf_write[2] !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ready=%b wbv=%b en=%b rdy=%b src=%0d id=%0d, required ready=1111 rest 0",
                     bus.fu_ready, bus.wb_valid, bus.prf_write_enable,
                     bus.set_prn_ready, bus.wb_src, bus.wb_inst_id);
         end
      end
      rst = 1'b1;
      bus.fu_valid = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if (bus.wb_valid !== 1'b0 || bus.fu_ready !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_release c=%0d: got wbv=%b ready=%b, required 0 and 1111",
                     c, bus.wb_valid, bus.fu_ready);
         end
      end
   endtask

   task automatic test_contention();
      exp_t x;
      int   got [$];
      int   first;
      first = -1;
      for (int i = 0; i < 4; i++) begin
         x = mk(i, 10 + i, 3'(i + 1),
                {6'(i + 30), 6'(i + 20), 6'(i + 10)}, rnd_data());
         put(x);
         sb.push_back(x);
      end
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) bus.fu_valid = '0;
         if (bus.wb_valid === 1'b1) begin
            if (first < 0) first = c;
            got.push_back(int'(bus.wb_inst_id));
         end
      end
      vectors++;
      if (first != LAT || got.size() != 4) begin
         miscompares++;
         $display("FAIL cont_timing: got first=%0d count=%0d, required first=%0d count=4",
                  first, got.size(), LAT);
      end
      foreach (got[n]) begin
         vectors++;
         if (got[n] != 10 + n) begin
            miscompares++;
            $display("FAIL cont_order n=%0d: got id=%0d, required %0d", n, got[n], 10 + n);
         end
      end
      vectors++;
      if (dut.r_ptr !== 2'd0 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL cont_ptr: got ptr=%0d left=%0d, required ptr=0 left=0",
                  dut.r_ptr, sb.size());
      end
   endtask

   task automatic test_single();
      exp_t x;
      x = mk(2, 5, 3'b101, {6'd9, 6'd63, 6'd7},
             {64'hB, 64'hDEAD, 64'hA});
      put(x);
      sb.push_back(x);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) bus.fu_valid = '0;
         vectors++;
         if (bus.wb_valid !== (c == LAT)) begin
            miscompares++;
            $display("FAIL single_latency c=%0d: got wbv=%b, required %b",
                     c, bus.wb_valid, c == LAT);
         end
         if (c == LAT) begin
            vectors++;
            if (bus.wb_src !== 2'd2 || bus.wb_inst_id !== 6'd5 ||
                bus.prf_write_enable !== 3'b101 ||
                bus.prf_write_prn[0] !== 6'd7 || bus.prf_write_prn[2] !== 6'd9 ||
                bus.prf_write[0] !== 64'hA || bus.prf_write[2] !== 64'hB) begin
               miscompares++;
               $display("FAIL single_fields: got src=%0d id=%0d en=%b prn0=%0d prn2=%0d d0=%h d2=%h, required 2 5 101 7 9 a b",
                        bus.wb_src, bus.wb_inst_id, bus.prf_write_enable,
                        bus.prf_write_prn[0], bus.prf_write_prn[2],
                        bus.prf_write[0], bus.prf_write[2]);
            end
         end
      end
   endtask

   task automatic test_zero_dest();
      exp_t x;
      bit   seen;
      seen = 1'b0;
      x = mk(1, 3, 3'b000, {6'd5, 6'd4, 6'd3}, rnd_data());
      put(x);
      sb.push_back(x);
      for (int c = 1; c <= 6 && !seen; c++) begin
         @(negedge clk);
         if (c == 1) bus.fu_valid = '0;
         if (bus.wb_valid === 1'b1) begin
            seen = 1'b1;
            vectors++;
            if (bus.wb_inst_id !== 6'd3 || bus.wb_src !== 2'd1 ||
                bus.prf_write_enable !== 3'b000 || bus.set_prn_ready !== 3'b000) begin
               miscompares++;
               $display("FAIL zero_dest: got id=%0d src=%0d en=%b rdy=%b, required 3 1 000 000",
                        bus.wb_inst_id, bus.wb_src, bus.prf_write_enable, bus.set_prn_ready);
            end
         end
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL zero_dest_timeout: got no wb_valid, required one pulse");
      end
   endtask

   task automatic test_back_to_back();
      exp_t       cur [4];
      logic [3:0] r;
      logic [3:0] prev;
      int         stall;
      int         nid;
      nid   = 20;
      prev  = '0;
      stall = 0;
      for (int i = 0; i < 4; i++) begin
         cur[i] = mk(i, nid, 3'($urandom_range(7)),
                     {6'($urandom), 6'($urandom), 6'($urandom)}, rnd_data());
         nid++;
         put(cur[i]);
      end
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (prev[i]) begin
               cur[i] = mk(i, nid, 3'($urandom_range(7)),
                           {6'($urandom), 6'($urandom), 6'($urandom)}, rnd_data());
               nid++;
               put(cur[i]);
            end
         end
         #1;
         r = bus.fu_ready;
         if (c > 0) begin
            vectors++;
            if ($countones(r) != 1) begin
               miscompares++;
               $display("FAIL bp_one_ready c=%0d: got ready=%b, required one-hot", c, r);
            end
         end
         stall = r[0] ? 0 : stall + 1;
         vectors++;
         if (stall > 3) begin
            miscompares++;
            $display("FAIL bp_starve c=%0d: got fu0 stall=%0d, required <=3", c, stall);
         end
         for (int i = 0; i < 4; i++)
            if (r[i]) sb.push_back(cur[i]);
         prev = r;
      end
      @(negedge clk);
      bus.fu_valid = '0;
      for (int c = 0; c < 12 && sb.size() > 0; c++) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL bp_drain: got %0d ids missing, required 0", sb.size());
      end
   endtask

   task automatic test_reset_midflight();
      put(mk(0, 50, 3'b111, {6'd2, 6'd1, 6'd0}, rnd_data()));
      put(mk(3, 53, 3'b011, {6'd5, 6'd4, 6'd3}, rnd_data()));
      @(negedge clk);
      bus.fu_valid = '0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++;
         if (bus.wb_valid !== 1'b0 || bus.fu_ready !== 4'hF || dut.r_ptr !== 2'd0) begin
            miscompares++;
            $display("FAIL midreset c=%0d: got wbv=%b ready=%b ptr=%0d, required 0 1111 0",
                     c, bus.wb_valid, bus.fu_ready, dut.r_ptr);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      bus.fu_valid = '0;
      for (int i = 0; i < 4; i++) begin
         bus.fu_inst_id[i]   = '0;
         bus.fu_prn_valid[i] = '0;
         for (int k = 0; k < MAX_OPERANDS; k++) begin
            bus.fu_prn[i][k]  = '0;
            bus.fu_data[i][k] = '0;
         end
      end
      test_reset();
      test_contention();
      test_single();
      test_zero_dest();
      test_back_to_back();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by 100000, required earlier finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that shares the single PRF write-port group, the ROB completion port and the wakeup broadcast among all functional units. Each FU hands its finished instruction (inst_id, up to MAX_OPERANDS destination PRNs and data) to a one-entry holding slot, and a round-robin scheduler drains one slot per cycle into registered writeback outputs. The arbiter sits between the FU/issue-queue wrappers and the PRF/ROB. Its wakeup outputs feed every issue queue's set_prn inputs.

## Interface
Parameters:
- INST_ID_BITS, 6, ROB instruction id width
- PRN_BITS, 6, physical register number width
- MAX_OPERANDS, 3, destination slots per instruction
- FU_COUNT, 4, number of requesting FUs (≥2)
- DATA_BITS, 64, register data width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- fu_valid[FU_COUNT]  in  1  FU result valid
- fu_ready[FU_COUNT]  out  1  arbiter can accept that FU's result this cycle
- fu_inst_id[FU_COUNT]  in  INST_ID_BITS  completing instruction id
- fu_prn_valid[FU_COUNT][MAX_OPERANDS]  in  1  destination slot used
- fu_prn[FU_COUNT][MAX_OPERANDS]  in  PRN_BITS  destination PRN
- fu_data[FU_COUNT][MAX_OPERANDS]  in  DATA_BITS  result data
- prf_write_enable[MAX_OPERANDS]  out  1  PRF write strobe
- prf_write_prn[MAX_OPERANDS]  out  PRN_BITS  PRF write address
- prf_write[MAX_OPERANDS]  out  DATA_BITS  PRF write data
- set_prn_ready[MAX_OPERANDS]  out  1  wakeup broadcast valid
- set_prn[MAX_OPERANDS]  out  PRN_BITS  wakeup broadcast PRN
- wb_valid  out  1  completion to ROB
- wb_inst_id  out  INST_ID_BITS  completed id
- wb_src  out  $clog2(FU_COUNT)  index of FU that produced this writeback

## Operation
- Per-FU slot {valid, inst_id, prn_valid[], prn[], data[]}.
- Capture: fu_valid[i] && fu_ready[i] at the clock edge loads slot i.
- fu_ready[i] = !slot_valid[i] || grant[i]. A full slot that is granted in the same cycle refills seamlessly.
- Arbitration (combinational):
  - Requesters are the slots with slot_valid set.
  - Search order starts at rr_ptr and wraps modulo FU_COUNT; the first requester found receives grant.
  - At most one grant per cycle.
- On grant at the edge:
  - wb registers load the granted slot's contents; wb_src is set to the granted index.
  - That slot clears unless it is refilled in the same cycle.
  - rr_ptr ← (granted index + 1) mod FU_COUNT.
  - With no grant, wb_valid ← 0 and rr_ptr holds.
- Output gating:
  - prf_write_enable[k] = set_prn_ready[k] = wb_valid && wb_prn_valid[k].
  - prf_write_prn and set_prn both equal wb_prn.
- Zero-destination results (all prn_valid=0) still arbitrate and produce a wb_valid pulse with no write enables.
- No starvation: a waiting slot is granted within FU_COUNT cycles.

## Timing
- Reset values (rst=0 at edge):
  - all slot_valid, wb_valid, prf_write_enable and set_prn_ready = 0.
  - rr_ptr = 0; wb_src = 0; wb_inst_id, prn and data registers = 0.
  - fu_ready reads 1 combinationally during and after reset.
  - Reset mid-operation discards every held result.
- Latency without bypass:
  - Result captured at edge t; earliest grant is in cycle t+1; wb_valid is high in cycle t+2.
- Throughput: one writeback per cycle sustained while any slot is valid.
- Simultaneous capture and grant on the same slot: the new data wins and the old data goes to wb.
- All FUs valid every cycle: grants rotate 0,1,…,FU_COUNT-1. No FU is ever stalled more than FU_COUNT-1 consecutive cycles.
- All slots empty: wb_valid=0 and rr_ptr is unchanged.

## Configuration
- WB_ARB_BYPASS_EN defined:
  - An FU whose slot is empty and that asserts fu_valid also competes in the same cycle's arbitration.
  - If it wins, its result goes straight to the wb registers and its slot stays empty, giving latency 1 (wb_valid at t+1).
  - An FU with a valid slot competes only with its slot contents.
- Not defined: only slot contents arbitrate, giving latency 2.
- fu_ready behaviour is identical in both builds.

## Structure
- Shared package wb_arb_pkg holds:
  - typedef wb_entry_t (valid, inst_id, prn_valid/prn/data arrays), parameterised via package localparams that match the core defaults;
  - the function rr_next(ptr, FU_COUNT).
- Sub-module rr_arbiter (FU_COUNT requests plus rr_ptr in; one-hot grant plus index out) is purely combinational.
- wb_arbiter owns the slots, the pointer and the output registers.

## Test plan
- Reset check: hold rst=0 for 2 cycles with all fu_valid=1. Expect every output 0, fu_ready all 1, and no wb_valid in the cycle after release.
- Single FU: FU2 presents id=5, prn_valid={1,0,1}, prn={7,x,9}, data={0xA,x,0xB} at cycle 0. Expect wb_valid, wb_src=2, id=5, enables {1,0,1}, prn {7,·,9}, data {0xA,·,0xB} at cycle 2 (cycle 1 with bypass).
- Contention: all four FUs are valid in one cycle with ids 10–13. Expect writebacks on 4 consecutive cycles in order 10,11,12,13, then rr_ptr=0.
- Backpressure: FU0 is valid on every cycle with a fresh id while FU1–FU3 slots are also full. Expect FU0's fu_ready low until its grant, and every id to appear exactly once.
- Zero-destination: FU1 presents id=3 with all prn_valid=0. Expect a wb_valid pulse with id=3 and no prf_write_enable or set_prn_ready.
- Reset mid-flight: fill slots 0 and 3, then assert rst for 1 cycle. Expect no writeback of either result afterwards.
